// File: rtl/gpio_pkg.sv
// Shared constants for the GPIO port bank: per-channel register map and limits.
package gpio_pkg;

  localparam int          MAX_N_CH  = 8;
  localparam int          CH_IDX_W  = $clog2(MAX_N_CH);
  localparam logic [31:0] CH_STRIDE = 32'h0000_0020;

  localparam logic [4:0] OFF_OUT   = 5'h00;
  localparam logic [4:0] OFF_DIR   = 5'h04;
  localparam logic [4:0] OFF_IN    = 5'h08;
  localparam logic [4:0] OFF_IEN   = 5'h0C;
  localparam logic [4:0] OFF_ISTAT = 5'h10;

  typedef enum logic [2:0] {
    REG_NONE,
    REG_OUT,
    REG_DIR,
    REG_IN,
    REG_IEN,
    REG_ISTAT
  } reg_sel_e;

  // Misaligned or reserved offsets inside a channel window decode to REG_NONE.
  function automatic reg_sel_e decode_reg(input logic [4:0] off);
    case (off)
      OFF_OUT:   return REG_OUT;
      OFF_DIR:   return REG_DIR;
      OFF_IN:    return REG_IN;
      OFF_IEN:   return REG_IEN;
      OFF_ISTAT: return REG_ISTAT;
      default:   return REG_NONE;
    endcase
  endfunction

endpackage

// File: rtl/gpio_sync.sv
// Two-flop synchronizer bringing asynchronous pin inputs into the clk_i domain.
module gpio_sync #(
  parameter int WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] meta_q;
  logic [WIDTH-1:0] sync_q;

  // NOTE: non-blocking assignments make both stages sample on the same edge,
  // so this is a real two-flop chain rather than a single collapsed flop.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/gpio_port_bank.sv
// Bank of N_CH GPIO channels with OUT/DIR/IN registers; define GPIO_IRQ_EN to add
// IEN/ISTAT rising-edge interrupt capture and the irq_o output.
module gpio_port_bank
  import gpio_pkg::*;
#(
  parameter int          WIDTH     = 32,
  parameter int          N_CH      = 4,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0100
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic [31:0]           addr_i,
  input  logic [31:0]           wdata_i,
  input  logic                  we_i,
  input  logic                  re_i,
  output logic [31:0]           rdata_o,
  output logic                  rvalid_o,
  input  logic [N_CH*WIDTH-1:0] gpio_in_i,
  output logic [N_CH*WIDTH-1:0] gpio_out_o,
  output logic [N_CH*WIDTH-1:0] gpio_oe_o,
  output logic                  irq_o
);

  localparam logic [31:0] SPAN = 32'(N_CH) * CH_STRIDE;

  logic [31:0]         off;
  logic                in_range;
  logic [CH_IDX_W-1:0] ch_idx;
  reg_sel_e            sel;
  logic [N_CH-1:0]     ch_sel;
  logic                wr_go;
  logic [WIDTH-1:0]    wr_val;

  logic [WIDTH-1:0] out_q   [N_CH];
  logic [WIDTH-1:0] dir_q   [N_CH];
  logic [WIDTH-1:0] ien_q   [N_CH];
  logic [WIDTH-1:0] istat_q [N_CH];
  logic [WIDTH-1:0] sync_w  [N_CH];

  logic [WIDTH-1:0] rd_word;
  logic [31:0]      rdata_d;
  logic [31:0]      rdata_q;
  logic             rvalid_q;

  // Addresses below the base wrap to huge offsets and fall outside SPAN.
  assign off      = addr_i - BASE_ADDR;
  assign in_range = (off < SPAN);
  assign ch_idx   = off[5 +: CH_IDX_W];
  assign sel      = in_range ? decode_reg(off[4:0]) : REG_NONE;
  assign wr_go    = we_i & ~re_i;
  assign wr_val   = wdata_i[WIDTH-1:0];

  // NOTE: every variable written in always_comb gets a default first, so no
  // path can leave it unassigned and infer a latch.
  always_comb begin
    ch_sel = '0;
    for (int c = 0; c < N_CH; c++) begin
      ch_sel[c] = (ch_idx == CH_IDX_W'(c));
    end
  end

  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    gpio_sync #(.WIDTH(WIDTH)) u_sync (
      .clk_i  (clk_i),
      .rst_ni (rst_ni),
      .d_i    (gpio_in_i[g*WIDTH +: WIDTH]),
      .q_o    (sync_w[g])
    );

    assign gpio_out_o[g*WIDTH +: WIDTH] = out_q[g];
    assign gpio_oe_o[g*WIDTH +: WIDTH]  = dir_q[g];
  end

  // NOTE: these arrays are plain flops, not a RAM macro, so every entry is
  // reset explicitly and gpio_out/gpio_oe never come up unknown.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      for (int c = 0; c < N_CH; c++) begin
        out_q[c] <= '0;
        dir_q[c] <= '0;
      end
    end else if (wr_go) begin
      for (int c = 0; c < N_CH; c++) begin
        if (ch_sel[c] && sel == REG_OUT) out_q[c] <= wr_val;
        if (ch_sel[c] && sel == REG_DIR) dir_q[c] <= wr_val;
      end
    end
  end

  always_comb begin
    rd_word = '0;
    for (int c = 0; c < N_CH; c++) begin
      if (ch_sel[c]) begin
        case (sel)
          REG_OUT:   rd_word = out_q[c];
          REG_DIR:   rd_word = dir_q[c];
          REG_IN:    rd_word = sync_w[c];
          REG_IEN:   rd_word = ien_q[c];
          REG_ISTAT: rd_word = istat_q[c];
          default:   rd_word = '0;
        endcase
      end
    end
    rdata_d = 32'(rd_word);
  end

  // rdata holds between reads; only rvalid pulses.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
    end else begin
      rvalid_q <= re_i;
      if (re_i) rdata_q <= rdata_d;
    end
  end

  assign rdata_o  = rdata_q;
  assign rvalid_o = rvalid_q;

`ifdef GPIO_IRQ_EN
  logic [WIDTH-1:0] prev_q  [N_CH];
  logic [WIDTH-1:0] istat_d [N_CH];
  logic [1:0]       warm_q;
  logic             edge_arm;
  logic             irq_d;
  logic             irq_q;

  // The synchronizer and history flops hold reset zeros for the first edges;
  // edges are only trusted once history holds a genuine pin sample.
  assign edge_arm = (warm_q == 2'd3);

  // A same-edge rising edge is ORed in after the W1C mask, so set wins.
  always_comb begin
    irq_d = 1'b0;
    for (int c = 0; c < N_CH; c++) begin
      istat_d[c] = (istat_q[c] &
                    ~((wr_go && ch_sel[c] && sel == REG_ISTAT) ? wr_val : '0)) |
                   (edge_arm ? (sync_w[c] & ~prev_q[c] & ien_q[c]) : '0);
      irq_d = irq_d | (|(istat_q[c] & ien_q[c]));
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      warm_q <= '0;
      irq_q  <= 1'b0;
      for (int c = 0; c < N_CH; c++) begin
        prev_q[c]  <= '0;
        ien_q[c]   <= '0;
        istat_q[c] <= '0;
      end
    end else begin
      if (!edge_arm) warm_q <= warm_q + 2'd1;
      irq_q <= irq_d;
      for (int c = 0; c < N_CH; c++) begin
        prev_q[c]  <= sync_w[c];
        istat_q[c] <= istat_d[c];
        if (wr_go && ch_sel[c] && sel == REG_IEN) ien_q[c] <= wr_val;
      end
    end
  end

  assign irq_o = irq_q;
`else
  always_comb begin
    for (int c = 0; c < N_CH; c++) begin
      ien_q[c]   = '0;
      istat_q[c] = '0;
    end
  end

  assign irq_o = 1'b0;
`endif

endmodule

// File: doc/gpio_port_bank.md
GPIO_PORT_BANK -- requirements
Module: gpio_port_bank

Interface
REQ-001 Parameter WIDTH, default 32, bits per channel (1..32).
REQ-002 Parameter N_CH, default 4, channel count (1..8).
REQ-003 Parameter BASE_ADDR, default 32'h0000_0100, byte base address of the bank.
REQ-004 clock  in  1  single clock; all state updates on rising edge.
REQ-005 reset  in  1  synchronous, active-low reset; sampled on the rising edge of clock.
REQ-006 addr  in  32  byte address of the register access.
REQ-007 wdata  in  32  write data; bits above WIDTH ignored.
REQ-008 we  in  1  write strobe, one access per cycle.
REQ-009 re  in  1  read strobe; when asserted together with we, the write is ignored.
REQ-010 rdata  out  32  registered read data; zero-extended above WIDTH.
REQ-011 rvalid  out  1  one-cycle pulse qualifying rdata.
REQ-012 gpio_in  in  N_CH*WIDTH  asynchronous pin inputs, channel c at bits [c*WIDTH +: WIDTH].
REQ-013 gpio_out  out  N_CH*WIDTH  output data registers.
REQ-014 gpio_oe  out  N_CH*WIDTH  output enables (1 = drive).
REQ-015 irq  out  1  level interrupt; present only under GPIO_IRQ_EN, otherwise tied 0.

Function
REQ-016 Channel c registers are at BASE_ADDR + c*0x20 + offset: 0x00 OUT (RW), 0x04 DIR (RW), 0x08 IN (RO), 0x0C IEN (RW), 0x10 ISTAT (W1C).
REQ-017 A write with we=1 to a matching address updates the register on the same edge; the new value is visible on gpio_out/gpio_oe in the next cycle.
REQ-018 A non-matching or unmapped address, or a write to IN, changes no state.
REQ-019 A read with re=1 returns the register value at the cycle edge; rdata and rvalid are valid exactly one cycle later.
REQ-020 A read of an unmapped address returns 0 with rvalid=1.
REQ-021 Outside a read, rdata holds its last value and rvalid=0.
REQ-022 IN returns gpio_in after the 2-stage synchronizer (latency of 2 cycles from pin to IN).
REQ-023 Each synchronized bit is compared with its previous synchronized value; a 0->1 transition on a bit with IEN=1 sets the matching ISTAT bit.
REQ-024 Writing 1 to an ISTAT bit clears it; writing 0 leaves it unchanged.
REQ-025 If a set and a clear hit the same ISTAT bit on the same edge, the set wins.
REQ-026 irq is registered: irq = OR over all channels of (ISTAT & IEN), with one cycle of latency.
REQ-027 A write to OUT while DIR=0 still stores the value; gpio_oe alone gates driving.

Reset
REQ-028 When reset=0 at an edge, the block loads OUT, DIR, IEN, ISTAT, the synchronizer stages, the edge history, rdata, rvalid and irq with 0.
REQ-029 Reset asserted mid-access discards the access, and no rvalid is produced for it.
REQ-030 After reset, no edge is detected until two synchronized samples have been taken.

Configuration
REQ-031 Macro GPIO_IRQ_EN: when defined, the block includes IEN, ISTAT, edge detection and irq.
REQ-032 When GPIO_IRQ_EN is not defined, IEN and ISTAT read 0, writes to them are ignored, and irq is constant 0.

Structure
REQ-033 Package gpio_pkg holds the register offset constants (OFF_OUT, OFF_DIR, OFF_IN, OFF_IEN, OFF_ISTAT), CH_STRIDE=0x20 and the maximum N_CH.
REQ-034 Sub-module gpio_sync is a parametrised-width, 2-flop synchronizer with synchronous active-low reset, instantiated once per channel.

Verification
REQ-035 Write 0xADF to OUT ch0, then DIR=0xFFFFFFFF -> gpio_out[31:0]=0xADF and gpio_oe[31:0]=all ones in the following cycle.
REQ-036 Write to BASE_ADDR+0x20 (ch1 OUT) with 0xABCD -> ch1 out=0xABCD and ch0 out is unchanged; a write to BASE_ADDR+0x200 changes nothing.
REQ-037 Drive gpio_in ch2=0x5, then read IN ch2 three cycles later -> rvalid one cycle after re, with rdata=0x5.
REQ-038 With GPIO_IRQ_EN defined: set IEN ch3=0x1 and raise gpio_in ch3 bit0 -> ISTAT ch3=0x1 and irq=1; writing 0x1 to ISTAT clears it and irq falls one cycle later.
REQ-039 With GPIO_IRQ_EN defined: apply a rising edge in the same cycle as a W1C on the same bit -> the bit stays 1.
REQ-040 Assert reset=0 for one cycle with nonzero registers and re=1 -> all outputs are 0 and no rvalid is produced.
